// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin N:1 AXI-Stream arbiter with a registered output stage.
// A granted channel keeps the link until its TLAST beat transfers, so packets never interleave.
package axis_rr_arbiter_pkg;
   localparam int AXIS_DATA_WIDTH = 40;

   typedef struct packed {
      logic [AXIS_DATA_WIDTH-1:0] tdata;
      logic                       tlast;
   } axis_data_t;

   typedef struct packed {
      axis_data_t data;
      logic       tvalid;
   } axis_mosi_t;

   typedef struct packed {
      logic tready;
   } axis_miso_t;
endpackage

// A beat moves on every rising edge where tvalid && tready are both high; a source never
// waits for tready before raising tvalid, and tready here never depends on a beat being held.
module axis_rr_arbiter #(
   parameter int  CHANNEL_NUMBER  = 8,
   parameter int  AXIS_DATA_WIDTH = axis_rr_arbiter_pkg::AXIS_DATA_WIDTH,
   localparam int SEL_WIDTH       = $clog2(CHANNEL_NUMBER)
) (
   input  logic                           ACLK,
   input  logic                           ARESETn,
   input  axis_rr_arbiter_pkg::axis_mosi_t in_mosi_i [CHANNEL_NUMBER],
   output axis_rr_arbiter_pkg::axis_miso_t in_miso_o [CHANNEL_NUMBER],
   output axis_rr_arbiter_pkg::axis_mosi_t out_mosi_o,
   input  axis_rr_arbiter_pkg::axis_miso_t out_miso_i,
   output logic [SEL_WIDTH-1:0]           out_src_o,
   output logic                           dbg_locked_o,
   output logic [SEL_WIDTH-1:0]           dbg_rr_ptr_o
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                          state;
   logic [SEL_WIDTH-1:0]            grant;
   logic [SEL_WIDTH-1:0]            rr_ptr;
   logic [SEL_WIDTH-1:0]            winner;
   logic [SEL_WIDTH-1:0]            src_q;
   logic                            any_valid;
   logic                            grant_ready;
   logic                            accept;
   logic                            out_valid_q;
   logic [AXIS_DATA_WIDTH-1:0]      sel_tdata;
   logic                            sel_tlast;
   axis_rr_arbiter_pkg::axis_data_t out_data_q;

   // Scan from the farthest channel back to rr_ptr so the closest valid one wins last.
   always_comb begin
      int                   idx;
      logic [SEL_WIDTH-1:0] pick;
      winner    = rr_ptr;
      any_valid = 1'b0;
      idx       = 0;
      pick      = '0;
      for (int k = CHANNEL_NUMBER - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= CHANNEL_NUMBER) idx = idx - CHANNEL_NUMBER;
         pick = idx[SEL_WIDTH-1:0];
         if (in_mosi_i[pick].tvalid) begin
            winner    = pick;
            any_valid = 1'b1;
         end
      end
   end

   assign sel_tdata   = in_mosi_i[grant].data.tdata;
   assign sel_tlast   = in_mosi_i[grant].data.tlast;
   assign grant_ready = (state == LOCKED) && (!out_valid_q || out_miso_i.tready);
   assign accept      = grant_ready && in_mosi_i[grant].tvalid;

   always_comb begin
      for (int i = 0; i < CHANNEL_NUMBER; i++) begin
         in_miso_o[i].tready = grant_ready && (grant == SEL_WIDTH'(i));
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state       <= IDLE;
         grant       <= '0;
         rr_ptr      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         src_q       <= '0;
      end else begin
         if (accept) begin
            out_data_q.tdata <= sel_tdata;
            out_data_q.tlast <= sel_tlast;
            out_valid_q      <= 1'b1;
            src_q            <= grant;
         end else if (out_miso_i.tready) begin
            out_valid_q <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (any_valid) begin
                  grant <= winner;
                  state <= LOCKED;
               end
            end
            LOCKED: begin
               if (accept && sel_tlast) begin
                  state  <= IDLE;
                  rr_ptr <= (grant == SEL_WIDTH'(CHANNEL_NUMBER - 1)) ? '0 : grant + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign out_mosi_o   = '{data: out_data_q, tvalid: out_valid_q};
   assign out_src_o    = src_q;
   assign dbg_locked_o = (state == LOCKED);
   assign dbg_rr_ptr_o = rr_ptr;

endmodule
